// File: rtl/clkdiv_bank.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_bank
//  Brief    : Bank of NCH programmable clock dividers gated by a filtered PLL
//             lock. Each channel has a divisor and start phase. Reconfiguration
//             while running is staged in a shadow register and applied at the
//             period boundary, so no runt pulses are produced.
//  Revision : 1.0 - initial release
// ============================================================================
module clkdiv_bank #(
  parameter int NCH         = 7,
  parameter int DW          = 8,
  parameter int LOCK_WAIT   = 16,
  parameter int DIV_DEFAULT = 2
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   lock_in,
  input  logic                                   sync_req,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [DW-1:0]                          cfg_div,
  input  logic [DW-1:0]                          cfg_phase,
  output logic [NCH-1:0]                         clkout,
  output logic [NCH-1:0]                         stb,
  output logic                                   lock
);

  localparam int              c_chw     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int              c_lcw     = $clog2(LOCK_WAIT + 1);
  localparam logic [DW-1:0]   c_div_rst = DW'(DIV_DEFAULT);

  typedef enum logic [0:0] {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [c_lcw-1:0]     lock_cnt_q, lock_cnt_d;
  logic                 run_q;
  logic                 enter_run;
  logic                 wr_acc;
  logic [NCH-1:0]       pend_vec;
  logic [(1<<c_chw)-1:0] pend_ext;

  // Start count for a channel: phase clamped into the period, 0 when disabled.
  function automatic logic [DW-1:0] eff_phase(input logic [DW-1:0] d,
                                               input logic [DW-1:0] p);
    if (d == '0) begin
      return '0;
    end else if (p >= d) begin
      return d - DW'(1);
    end else begin
      return p;
    end
  endfunction

  // Divided clock level for a given count: high in the first half period.
  function automatic logic clk_level(input logic [DW-1:0] d,
                                     input logic [DW-1:0] c);
    return (d == DW'(1)) || (c < (d >> 1));
  endfunction

  // Strobe on the last count of the period.
  function automatic logic stb_level(input logic [DW-1:0] d,
                                     input logic [DW-1:0] c);
    return (d != '0) && (c == d - DW'(1));
  endfunction

  // State register and lock filter counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Next state: wait for LOCK_WAIT consecutive lock_in samples, drop on any low.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (!lock_in) begin
          lock_cnt_d = '0;
        end else if (32'(lock_cnt_q) + 32'd1 >= 32'(LOCK_WAIT)) begin
          state_d    = RUN;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + c_lcw'(1);
        end
      end
      RUN: begin
        lock_cnt_d = '0;
        if (!lock_in) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
      end
    endcase
  end

  assign run_q     = (state_q == RUN);
  assign lock      = run_q;
  assign enter_run = (state_q == WAIT_LOCK) && (state_d == RUN);

  // Pending flags widened to the full cfg_ch range; unused channels read 0.
  always_comb begin
    pend_ext          = '0;
    pend_ext[NCH-1:0] = pend_vec;
  end

  // A channel with a staged update refuses further writes until it is applied.
  assign cfg_ready = !run_q || !pend_ext[cfg_ch];
  assign wr_acc    = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [c_chw-1:0] c_idx = c_chw'(i);

    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] phase_q, phase_d;
    logic [DW-1:0] sdiv_q, sdiv_d;
    logic [DW-1:0] sphase_q, sphase_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          clk_q, clk_d;
    logic          stb_q, stb_d;
    logic          wr_hit;
    logic          apply;

    assign wr_hit = wr_acc && (cfg_ch == c_idx);
    // Apply a staged update at the period boundary, on sync, or at once when
    // the channel has no meaningful period (div <= 1).
    assign apply  = pend_q && (sync_req || stb_q || (div_q <= DW'(1)));

    // Channel next-state: counter, active/shadow configuration, outputs.
    always_comb begin
      div_d    = div_q;
      phase_d  = phase_q;
      sdiv_d   = sdiv_q;
      sphase_d = sphase_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      clk_d    = 1'b0;
      stb_d    = 1'b0;
      if (!run_q) begin
        if (wr_hit) begin
          div_d   = cfg_div;
          phase_d = cfg_phase;
        end
        if (enter_run) begin
          cnt_d = eff_phase(div_d, phase_d);
          clk_d = clk_level(div_d, cnt_d);
          stb_d = stb_level(div_d, cnt_d);
        end else begin
          cnt_d = '0;
        end
      end else if (!lock_in) begin
        // Losing lock: flush any staged value into the active registers.
        if (pend_q) begin
          div_d   = sdiv_q;
          phase_d = sphase_q;
          pend_d  = 1'b0;
        end
        if (wr_hit) begin
          div_d   = cfg_div;
          phase_d = cfg_phase;
        end
        cnt_d = '0;
      end else begin
        if (apply) begin
          div_d   = sdiv_q;
          phase_d = sphase_q;
          pend_d  = 1'b0;
          cnt_d   = eff_phase(sdiv_q, sphase_q);
        end else if (sync_req) begin
          cnt_d = eff_phase(div_q, phase_q);
        end else if (div_q <= DW'(1)) begin
          cnt_d = '0;
        end else if (cnt_q == div_q - DW'(1)) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
        if (wr_hit) begin
          sdiv_d   = cfg_div;
          sphase_d = cfg_phase;
          pend_d   = 1'b1;
        end
        clk_d = clk_level(div_d, cnt_d);
        stb_d = stb_level(div_d, cnt_d);
      end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        div_q    <= c_div_rst;
        phase_q  <= '0;
        sdiv_q   <= '0;
        sphase_q <= '0;
        pend_q   <= 1'b0;
        cnt_q    <= '0;
        clk_q    <= 1'b0;
        stb_q    <= 1'b0;
      end else begin
        div_q    <= div_d;
        phase_q  <= phase_d;
        sdiv_q   <= sdiv_d;
        sphase_q <= sphase_d;
        pend_q   <= pend_d;
        cnt_q    <= cnt_d;
        clk_q    <= clk_d;
        stb_q    <= stb_d;
      end
    end

    assign clkout[i]   = clk_q;
    assign stb[i]      = stb_q;
    assign pend_vec[i] = pend_q;
  end

endmodule
`default_nettype wire

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 SHALL have parameter NCH, default 7, number of divided-clock channels (1..16).
REQ-002 SHALL have parameter DW, default 8, width of divisor and phase fields.
REQ-003 SHALL have parameter LOCK_WAIT, default 16, consecutive lock_in-high cycles required before lock asserts (>=1).
REQ-004 SHALL have parameter DIV_DEFAULT, default 2, reset divisor of every channel (1..2^DW-1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port lock_in  input  1  raw PLL lock, synchronous to clk.
REQ-008 SHALL have port sync_req  input  1  one-cycle pulse; phase-aligns all channels.
REQ-009 SHALL have port cfg_valid  input  1  configuration write request.
REQ-010 SHALL have port cfg_ready  output  1  configuration write can be accepted.
REQ-011 SHALL have port cfg_ch  input  max(1,clog2(NCH))  target channel.
REQ-012 SHALL have port cfg_div  input  DW  new divisor; 0 = channel disabled.
REQ-013 SHALL have port cfg_phase  input  DW  new start phase, in clk cycles.
REQ-014 SHALL have port clkout  output  NCH  divided clocks, registered.
REQ-015 SHALL have port stb  output  NCH  one-cycle pulse at the last cycle of each period, registered.
REQ-016 SHALL have port lock  output  1  filtered lock; channels run only while high.

Function
REQ-017 SHALL implement states WAIT_LOCK and RUN; WAIT_LOCK->RUN when lock_in has been high for LOCK_WAIT consecutive cycles; RUN->WAIT_LOCK in the cycle after lock_in is sampled low.
REQ-018 SHALL clear the lock filter counter whenever lock_in is low; lock = 1 exactly while in RUN.
REQ-019 SHALL, in WAIT_LOCK, hold all channel counters, clkout and stb at 0.
REQ-020 SHALL, per channel, keep active div/phase and a counter cnt; on every entry to RUN, cnt loads eff_phase = min(phase, div-1).
REQ-021 SHALL, in RUN with div>=2, advance cnt by 1 each cycle, wrapping from div-1 to 0.
REQ-022 SHALL, in each cycle, drive clkout[i] = (cnt < div>>1) and stb[i] = (cnt == div-1), both as flops whose value matches the cnt of that cycle.
REQ-023 SHALL, for div=1, drive clkout[i]=1 and stb[i]=1 every RUN cycle; for div=0, hold clkout[i]=0, stb[i]=0, cnt=0.
REQ-024 SHALL accept a write when cfg_valid && cfg_ready; cfg_ch >= NCH is accepted and discarded.
REQ-025 SHALL, in WAIT_LOCK, drive cfg_ready=1 and apply accepted writes directly to active div/phase.
REQ-026 SHALL, in RUN, store an accepted write in the channel's shadow register and set pending[ch]; cfg_ready = !pending[cfg_ch].
REQ-027 SHALL apply a pending update in the cycle after the channel's stb (or the next cycle if active div<=1 or 0): load div/phase, set cnt = eff_phase of the new values, clear pending; no runt clkout pulse shall result.
REQ-028 SHALL, on sync_req in RUN, first apply all pending updates, then load every channel's cnt with its eff_phase in the next cycle; sync_req in WAIT_LOCK is ignored.
REQ-029 SHALL, if lock_in drops while updates are pending, apply pending values on entry to WAIT_LOCK and clear pending.
REQ-030 SHALL, when a write and a pending-apply target the same channel in one cycle, block the write (cfg_ready=0 already).

Reset
REQ-031 SHALL, when resetn is low at a clk edge, set state=WAIT_LOCK, lock filter=0, lock=0, all div=DIV_DEFAULT, phase=0, cnt=0, pending=0, clkout=0, stb=0; cfg_ready=1 in the following cycle.
REQ-032 SHALL allow reset mid-operation with the same result; no shadow value survives reset.

Verification
REQ-033 SHALL cover lock filter: LOCK_WAIT=16, lock_in high 10 cycles, low 1, high 16 -> lock rises exactly 16 cycles after the final rise; never during the first burst.
REQ-034 SHALL cover divide: ch0 div=5 phase=0 -> clkout0 pattern 1,1,0,0,0 repeating, stb0 on 5th cycle of each period.
REQ-035 SHALL cover phase: ch1 div=4 phase=2, ch2 div=4 phase=0, sync_req -> ch1 stb fires 2 cycles before ch2 stb; phase=9 with div=4 is treated as 3.
REQ-036 SHALL cover glitch-free reconfig in RUN: ch0 div 4->7 written mid-period -> old period completes, next 7-cycle period starts after stb, cfg_ready low for ch0 until applied.
REQ-037 SHALL cover lock loss: lock_in low for 1 cycle in RUN -> lock=0, all clkout/stb=0 next cycle, relock after 16 cycles with counters at phase.
REQ-038 SHALL cover resetn low mid-run with pending write -> all outputs 0, div=DIV_DEFAULT, pending cleared.
